// File: rtl/sophon_pkg.sv
// Shared LSU types plus the APB bridge state encoding.
package sophon_pkg;

   // Channel-2 peripheral window served by the APB bridge
   localparam logic [31:0] CH2_BASE = 32'h0009_0000;
   localparam logic [31:0] CH2_END  = 32'h0009_FFFF;

   typedef struct packed {
      logic        req;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic        amo;
      logic [1:0]  size;
   } lsu_req_t;

   typedef struct packed {
      logic        ack;
      logic        error;
      logic [31:0] rdata;
   } lsu_ack_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_br_state_e;

   // APB addresses are always word aligned
   function automatic logic [31:0] apb_word_addr(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/lsu_apb_bridge.sv
// LSU channel-2 request -> single APB4 master transfer, one outstanding.
// Optional ACCESS-phase timeout enabled by defining LSU_APB_TIMEOUT_EN.
module lsu_apb_bridge
   import sophon_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  lsu_req_t    lsu_req_i,
   output lsu_ack_t    lsu_ack_o,
   output logic        psel_o,
   output logic        penable_o,
   output logic        pwrite_o,
   output logic [31:0] paddr_o,
   output logic [31:0] pwdata_o,
   output logic [3:0]  pstrb_o,
   input  logic [31:0] prdata_i,
   input  logic        pready_i,
   input  logic        pslverr_i
);

   apb_br_state_e r_state, w_state;

   logic        r_psel,    w_psel;
   logic        r_penable, w_penable;
   logic        r_pwrite,  w_pwrite;
   logic [31:0] r_paddr,   w_paddr;
   logic [31:0] r_pwdata,  w_pwdata;
   logic [3:0]  r_pstrb,   w_pstrb;
   logic        r_ack,     w_ack;
   logic        r_error,   w_error;
   logic [31:0] r_rdata,   w_rdata;

`ifdef LSU_APB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt, w_cnt;
`endif

   // size is informational only; strobes carry the byte enables
   logic w_unused;
   assign w_unused = &{1'b0, lsu_req_i.size};

   // State and all output registers; async reset returns everything to idle
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_psel    <= 1'b0;
         r_penable <= 1'b0;
         r_pwrite  <= 1'b0;
         r_paddr   <= '0;
         r_pwdata  <= '0;
         r_pstrb   <= '0;
         r_ack     <= 1'b0;
         r_error   <= 1'b0;
         r_rdata   <= '0;
`ifdef LSU_APB_TIMEOUT_EN
         r_cnt     <= '0;
`endif
      end else begin
         r_state   <= w_state;
         r_psel    <= w_psel;
         r_penable <= w_penable;
         r_pwrite  <= w_pwrite;
         r_paddr   <= w_paddr;
         r_pwdata  <= w_pwdata;
         r_pstrb   <= w_pstrb;
         r_ack     <= w_ack;
         r_error   <= w_error;
         r_rdata   <= w_rdata;
`ifdef LSU_APB_TIMEOUT_EN
         r_cnt     <= w_cnt;
`endif
      end
   end

   // Next-state and next-output decode; ack/error/rdata are nonzero only entering RESP
   always_comb begin
      w_state   = r_state;
      w_psel    = r_psel;
      w_penable = r_penable;
      w_pwrite  = r_pwrite;
      w_paddr   = r_paddr;
      w_pwdata  = r_pwdata;
      w_pstrb   = r_pstrb;
      w_ack     = 1'b0;
      w_error   = 1'b0;
      w_rdata   = '0;
`ifdef LSU_APB_TIMEOUT_EN
      w_cnt     = r_cnt;
`endif

      unique case (r_state)
         IDLE: begin
            if (lsu_req_i.req) begin
               if (lsu_req_i.amo) begin
                  w_state = RESP;
                  w_ack   = 1'b1;
                  w_error = 1'b1;
               end else begin
                  w_state   = SETUP;
                  w_psel    = 1'b1;
                  w_penable = 1'b0;
                  w_pwrite  = lsu_req_i.we;
                  w_paddr   = apb_word_addr(lsu_req_i.addr);
                  w_pwdata  = lsu_req_i.wdata;
                  w_pstrb   = lsu_req_i.we ? lsu_req_i.strb : 4'b0000;
               end
            end
         end

         SETUP: begin
            w_state   = ACCESS;
            w_penable = 1'b1;
`ifdef LSU_APB_TIMEOUT_EN
            w_cnt     = '0;
`endif
         end

         ACCESS: begin
            if (pready_i) begin
               w_state   = RESP;
               w_psel    = 1'b0;
               w_penable = 1'b0;
               w_ack     = 1'b1;
               w_error   = pslverr_i;
               w_rdata   = r_pwrite ? 32'h0 : prdata_i;
            end
`ifdef LSU_APB_TIMEOUT_EN
            else if (r_cnt == CNT_LAST) begin
               w_state   = RESP;
               w_psel    = 1'b0;
               w_penable = 1'b0;
               w_ack     = 1'b1;
               w_error   = 1'b1;
               w_cnt     = '0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
`endif
         end

         RESP: begin
            w_state = IDLE;
         end

         default: begin
            w_state = IDLE;
         end
      endcase
   end

   assign psel_o          = r_psel;
   assign penable_o       = r_penable;
   assign pwrite_o        = r_pwrite;
   assign paddr_o         = r_paddr;
   assign pwdata_o        = r_pwdata;
   assign pstrb_o         = r_pstrb;
   assign lsu_ack_o.ack   = r_ack;
   assign lsu_ack_o.error = r_error;
   assign lsu_ack_o.rdata = r_rdata;

endmodule
